// File: rtl/serial_full_add.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first,
// with a start/busy/done handshake around an N-cycle add.
module serial_full_add #(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] sum,
   output logic         co,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [N-1:0]     sa;
   logic [N-1:0]     sb;
   logic [N-1:0]     ps;
   logic             c;
   logic [CNT_W-1:0] cnt;

   logic             s_bit;
   logic             c_nxt;
   logic [N-1:0]     ps_nxt;
   logic             last_bit;

   // Single full-adder cell; the new sum bit enters the partial sum at the MSB.
   always_comb begin
      s_bit    = sa[0] ^ sb[0] ^ c;
      c_nxt    = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
      ps_nxt   = N'({s_bit, ps} >> 1);
      last_bit = (cnt == CNT_W'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         ps    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         co    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            // DONE accepts exactly like IDLE so back-to-back operations need no bubble.
            IDLE, DONE: begin
               busy <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  c     <= ci;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ADD;
               end else begin
                  state <= IDLE;
               end
            end
            ADD: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               c   <= c_nxt;
               ps  <= ps_nxt;
               cnt <= cnt + CNT_W'(1);
               if (last_bit) begin
                  sum   <= ps_nxt;
                  co    <= c_nxt;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_full_add.sv
// Scoreboard bench for serial_full_add: the driver pushes {co,sum} = a+b+ci and the
// expected done cycle; a negedge monitor pops on every done pulse.
module tb_serial_full_add;

   localparam int unsigned N = 4;

   typedef struct {
      logic [N-1:0] sum;
      logic         co;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         ci;
   logic [N-1:0] sum;
   logic         co;
   logic         busy;
   logic         done;

   exp_t         sbq[$];
   int           n_tests  = 0;
   int           n_fail   = 0;
   int           n_acc    = 0;
   int           n_done   = 0;
   int           cyc      = 0;
   int           busy_run = 0;
   logic [N:0]   last_res = '0;

   serial_full_add #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .sum   (sum),
      .co    (co),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One clock: record an acceptance with its reference result, then advance to posedge+1.
   task automatic step(output bit acc);
      logic [N:0] r;
      exp_t       e;
      acc = start && !busy && !rst;
      if (acc) begin
         r     = (N+1)'(a) + (N+1)'(b) + (N+1)'(ci);
         e.sum = r[N-1:0];
         e.co  = r[N];
         e.cyc = cyc + 1 + int'(N);
         sbq.push_back(e);
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tci,
                     input int gap);
      bit acc;
      int guard;
      a     = ta;
      b     = tb_v;
      ci    = tci;
      start = 1'b1;
      guard = 0;
      do begin
         step(acc);
         guard++;
      end while (!acc && guard < 4 * int'(N) + 8);
      if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
      start = 1'b0;
      repeat (gap) step(acc);
   endtask

   // Monitor: results and latency on done, hold of sum/co otherwise, busy run length.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         last_res = '0;
         busy_run = 0;
      end else begin
         if (done) begin
            n_done++;
            if (sbq.size() == 0) begin
               chk("done_without_start", 32'(done), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("result", 32'({co, sum}), 32'({e.co, e.sum}));
               chk("latency", 32'(cyc), 32'(e.cyc));
               last_res = {e.co, e.sum};
            end
         end else begin
            chk("hold", 32'({co, sum}), 32'(last_res));
         end
         if (busy) begin
            busy_run++;
         end else if (busy_run != 0) begin
            chk("busy_len", 32'(busy_run), 32'(N));
            busy_run = 0;
         end
      end
   end

   initial begin
      bit acc;
      int guard;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      ci    = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_co", 32'(co), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      repeat (2) step(acc);

      // Directed vectors, including wrap cases
      op(4'h0, 4'h0, 1'b0, 2);
      op(4'hF, 4'h1, 1'b0, 1);
      op(4'hA, 4'h5, 1'b1, 0);
      op(4'h3, 4'h4, 1'b1, 3);
      op(4'hF, 4'hF, 1'b1, 2);

      // start held through ADD with operands changed mid-operation
      a     = 4'h2;
      b     = 4'h2;
      ci    = 1'b0;
      start = 1'b1;
      guard = 0;
      do begin step(acc); guard++; end while (!acc && guard < 20);
      a     = 4'h7;
      b     = 4'h7;
      guard = 0;
      do begin step(acc); guard++; end while (!acc && guard < 20);
      chk("held_start_reaccept", 32'(acc), 32'd1);
      start = 1'b0;
      step(acc);

      // Reset during the second ADD cycle aborts the operation
      op(4'hF, 4'hF, 1'b0, 0);
      step(acc);
      rst = 1'b1;
      void'(sbq.pop_back());
      n_acc--;
      step(acc);
      rst = 1'b0;
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_co", 32'(co), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (N + 3) step(acc);

      // Exhaustive operand sweep with random inter-start gaps
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            for (int k = 0; k < 2; k++)
               op(4'(i), 4'(j), 1'(k), int'($urandom_range(0, 3)));

      // Random back-to-back burst
      for (int i = 0; i < 40; i++)
         op(4'($urandom), 4'($urandom), 1'($urandom), 0);

      guard = 0;
      while (sbq.size() != 0 && guard < 100) begin
         step(acc);
         guard++;
      end
      step(acc);
      chk("drain", 32'(sbq.size()), 32'd0);
      chk("done_count", 32'(n_done), 32'(n_acc));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
